// File: rtl/paper_run_ctrl_pkg.sv
// Shared definitions for the paper-processor run controller.
//   - command opcodes carried on cmd_op
//   - run-control FSM state encodings (also visible on the status output)
//   - program-counter / instruction-memory sizing and cycle-counter width
//   - cmd_is_illegal(): which accepted commands raise the err pulse
package paper_run_ctrl_pkg;

  localparam int PC_W           = 2;
  localparam int PROG_DEPTH_DEF = 1 << PC_W;
  localparam int INSN_W         = 2;
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_RUN  = 2'd1,
    OP_STEP = 2'd2,
    OP_STOP = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_HALTED  = 3'd4,
    ST_TIMEOUT = 3'd5
  } run_state_e;

  // An accepted command is illegal when it has no meaning in the current
  // state. STEP never accepts commands, so nothing there is illegal.
  function automatic logic cmd_is_illegal(input run_state_e st, input cmd_op_e op);
    logic bad;
    bad = 1'b0;
    case (st)
      ST_RUN, ST_HALTED, ST_TIMEOUT: bad = (op != OP_STOP);
      ST_PAUSED:                     bad = (op == OP_LOAD);
      default:                       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/paper_cycle_counter.sv
// Saturating counter of enabled core cycles.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the count (takes priority over enable)
//   enable     : count this cycle
//   limit      : saturation value
//   count      : registered count, never exceeds limit
//   hit        : this enabled cycle's increment reaches limit (combinational
//                from registered count, enable and the constant limit)
module paper_cycle_counter
  import paper_run_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  logic [CNT_W:0] count_inc_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cur,
                                                input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] nxt;
    if (cur >= lim) nxt = lim;
    else            nxt = cur + CNT_W'(1);
    return nxt;
  endfunction

  // One extra bit so a limit of 255 does not wrap the compare.
  assign count_inc_p0 = {1'b0, count} + (CNT_W+1)'(1);
  assign hit          = enable && (count_inc_p0 >= {1'b0, limit});

  // ---- stage p0 -> count register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= sat_inc(count, limit);
    end
  end

endmodule

// File: rtl/paper_run_ctrl.sv
// Run controller for the paper processor.
//   clk, reset            : clock, synchronous active-high reset
//   cmd_valid/op/addr/data: command channel (LOAD/RUN/STEP/STOP), cmd_ready
//                           handshake
//   core_halt             : halt decode from the core
//   core_clk_en/core_reset: core and counter control, decoded from state
//   prog_we/waddr/wdata   : registered instruction-memory write port
//   cycle_count           : saturating count of enabled core cycles
//   status                : FSM state encoding
//   done/timeout/err      : halted level, watchdog level, illegal-command pulse
// Every output is either a register or a decode of the state register.
module paper_run_ctrl
  import paper_run_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = 64,
  parameter int PROG_DEPTH = PROG_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [PC_W-1:0]   cmd_addr,
  input  logic [INSN_W-1:0] cmd_data,
  output logic              cmd_ready,
  input  logic              core_halt,
  output logic              core_clk_en,
  output logic              core_reset,
  output logic              prog_we,
  output logic [PC_W-1:0]   prog_waddr,
  output logic [INSN_W-1:0] prog_wdata,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [2:0]        status,
  output logic              done,
  output logic              timeout,
  output logic              err
);

  run_state_e state, next_state;
  cmd_op_e    op;
  logic       accept;
  logic       load_p0;
  logic       err_p0;
  logic       cnt_clear;
  logic       cnt_hit;

  // ---- state decodes ----
  assign cmd_ready   = (state != ST_STEP);
  assign core_reset  = (state == ST_IDLE);
  assign core_clk_en = (state == ST_RUN) || (state == ST_STEP);
  assign done        = (state == ST_HALTED);
  assign timeout     = (state == ST_TIMEOUT);
  assign status      = state;

  assign op     = cmd_op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready;

  // Next-state logic. In RUN/STEP the core's halt beats the watchdog, which
  // beats a STOP; a STOP lost that way is simply swallowed.
  always_comb begin
    next_state = state;
    load_p0    = 1'b0;
    err_p0     = accept && cmd_is_illegal(state, op);
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_LOAD: load_p0    = 1'b1;
            OP_RUN:  next_state = ST_RUN;
            OP_STEP: next_state = ST_STEP;
            default: next_state = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (core_halt)                     next_state = ST_HALTED;
        else if (cnt_hit)                  next_state = ST_TIMEOUT;
        else if (accept && op == OP_STOP)  next_state = ST_PAUSED;
      end
      ST_STEP: begin
        if (core_halt)    next_state = ST_HALTED;
        else if (cnt_hit) next_state = ST_TIMEOUT;
        else              next_state = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (accept) begin
          case (op)
            OP_RUN:  next_state = ST_RUN;
            OP_STEP: next_state = ST_STEP;
            OP_STOP: next_state = ST_IDLE;
            default: next_state = ST_PAUSED;
          endcase
        end
      end
      ST_HALTED, ST_TIMEOUT: begin
        if (accept && op == OP_STOP) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Clearing on the transition makes the count read zero on the first
  // IDLE cycle rather than one cycle later.
  assign cnt_clear = (next_state == ST_IDLE);

  // ---- stage p0 -> registered state, write port and err pulse ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      prog_we    <= 1'b0;
      prog_waddr <= '0;
      prog_wdata <= '0;
      err        <= 1'b0;
    end else begin
      state   <= next_state;
      prog_we <= load_p0;
      err     <= err_p0;
      if (load_p0) begin
        // Wrap the address into the configured memory depth.
        prog_waddr <= cmd_addr & PC_W'(PROG_DEPTH - 1);
        prog_wdata <= cmd_data;
      end
    end
  end

  paper_cycle_counter u_cycle_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (core_clk_en),
    .limit  (CNT_W'(MAX_CYCLES)),
    .count  (cycle_count),
    .hit    (cnt_hit)
  );

endmodule

// File: tb/tb_paper_run_ctrl.sv
module tb_paper_run_ctrl;

  localparam int MAXC = 8;

  localparam logic [1:0] C_LOAD = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_STEP = 2'd2;
  localparam logic [1:0] C_STOP = 2'd3;

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_PAUSED = 3, M_HALTED = 4, M_TIMEOUT = 5;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [1:0] cmd_addr;
  logic [1:0] cmd_data;
  logic       cmd_ready;
  logic       core_halt;
  logic       core_clk_en;
  logic       core_reset;
  logic       prog_we;
  logic [1:0] prog_waddr;
  logic [1:0] prog_wdata;
  logic [7:0] cycle_count;
  logic [2:0] status;
  logic       done;
  logic       timeout;
  logic       err;

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the controller as seen from its ports.
  int m_mode, m_cnt, m_waddr, m_wdata;
  bit m_we, m_err;

  logic [1:0] mem [4];

  paper_run_ctrl #(.MAX_CYCLES(MAXC)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .core_halt   (core_halt),
    .core_clk_en (core_clk_en),
    .core_reset  (core_reset),
    .prog_we     (prog_we),
    .prog_waddr  (prog_waddr),
    .prog_wdata  (prog_wdata),
    .cycle_count (cycle_count),
    .status      (status),
    .done        (done),
    .timeout     (timeout),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory as the core would see it.
  always @(posedge clk) if (prog_we) mem[prog_waddr] <= prog_wdata;

  function automatic logic [21:0] pack_obs();
    return {status, core_reset, core_clk_en, cmd_ready, done, timeout, err,
            prog_we, prog_waddr, prog_wdata, cycle_count};
  endfunction

  function automatic logic [21:0] model_vec();
    return {3'(m_mode), m_mode == M_IDLE, (m_mode == M_RUN) || (m_mode == M_STEP),
            m_mode != M_STEP, m_mode == M_HALTED, m_mode == M_TIMEOUT, m_err,
            m_we, 2'(m_waddr), 2'(m_wdata), 8'(m_cnt)};
  endfunction

  task automatic model_update(input bit rst, input bit v, input logic [1:0] op,
                              input logic [1:0] a, input logic [1:0] d, input bit h);
    int nm, nc;
    bit acc;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
      return;
    end
    acc  = v && (m_mode != M_STEP);
    nm   = m_mode;
    nc   = m_cnt;
    m_we = 0;
    m_err = 0;
    if (m_mode == M_IDLE) begin
      if (acc && op == C_LOAD) begin m_we = 1; m_waddr = int'(a); m_wdata = int'(d); end
      if (acc && op == C_RUN)  nm = M_RUN;
      if (acc && op == C_STEP) nm = M_STEP;
    end else if (m_mode == M_RUN || m_mode == M_STEP) begin
      nc = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
      if (acc && op != C_STOP) m_err = 1;
      if (h)                                          nm = M_HALTED;
      else if (nc >= MAXC)                            nm = M_TIMEOUT;
      else if (m_mode == M_STEP || (acc && op == C_STOP)) nm = M_PAUSED;
    end else if (m_mode == M_PAUSED) begin
      if (acc) begin
        if (op == C_LOAD) m_err = 1;
        if (op == C_RUN)  nm = M_RUN;
        if (op == C_STEP) nm = M_STEP;
        if (op == C_STOP) nm = M_IDLE;
      end
    end else begin
      if (acc && op == C_STOP) nm = M_IDLE;
      else if (acc)            m_err = 1;
    end
    if (nm == M_IDLE) nc = 0;
    m_mode = nm;
    m_cnt  = nc;
  endtask

  // Drive one cycle, advance the model on the same edge, settle #1 after it.
  task automatic cyc(input bit rst, input bit v, input logic [1:0] op,
                     input logic [1:0] a, input logic [1:0] d, input bit h);
    reset = rst; cmd_valid = v; cmd_op = op; cmd_addr = a; cmd_data = d; core_halt = h;
    @(posedge clk);
    model_update(rst, v, op, a, d, h);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, C_LOAD, 2'd0, 2'd0, 0);
  endtask

  task automatic test_reset();
    logic [21:0] want;
    want = {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0};
    cyc(1, 0, C_LOAD, 2'd0, 2'd0, 0);
    cyc(1, 1, C_RUN, 2'd0, 2'd0, 1);
    checks++;
    if (pack_obs() !== want) begin
      failures++; $display("FAIL reset_values got=%h want=%h", pack_obs(), want);
    end
    cyc(0, 0, C_LOAD, 2'd0, 2'd0, 0);
    checks++;
    if (status !== 3'd0 || core_reset !== 1'b1) begin
      failures++; $display("FAIL reset_release_idle got=%0d/%0b want=0/1", status, core_reset);
    end
  endtask

  task automatic test_load_run();
    logic [1:0] words [4];
    words[0] = 2'd1; words[1] = 2'd2; words[2] = 2'd0; words[3] = 2'd3;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, C_LOAD, 2'(i), words[i], 0);
      checks++;
      if (prog_we !== 1'b1 || prog_waddr !== 2'(i) || prog_wdata !== words[i] || core_clk_en !== 1'b0) begin
        failures++;
        $display("FAIL load_pulse%0d got we=%0b a=%0d d=%0d en=%0b want we=1 a=%0d d=%0d en=0",
                 i, prog_we, prog_waddr, prog_wdata, core_clk_en, i, words[i]);
      end
    end
    cyc(0, 1, C_RUN, 2'd0, 2'd0, 0);
    checks++;
    if (core_clk_en !== 1'b1 || core_reset !== 1'b0 || prog_we !== 1'b0 || status !== 3'd1) begin
      failures++;
      $display("FAIL run_start got en=%0b rst=%0b we=%0b st=%0d want en=1 rst=0 we=0 st=1",
               core_clk_en, core_reset, prog_we, status);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[i] !== words[i]) begin
        failures++; $display("FAIL mem%0d got=%0d want=%0d", i, mem[i], words[i]);
      end
    end
  endtask

  task automatic test_halt();
    // Continues from RUN with cycle_count=0; halt lands on the 5th cycle.
    idle_cycles(4);
    checks++;
    if (cycle_count !== 8'd4 || status !== 3'd1) begin
      failures++; $display("FAIL halt_pre got cnt=%0d st=%0d want cnt=4 st=1", cycle_count, status);
    end
    cyc(0, 0, C_LOAD, 2'd0, 2'd0, 1);
    checks++;
    if (status !== 3'd4 || done !== 1'b1 || cycle_count !== 8'd5 || core_clk_en !== 1'b0) begin
      failures++;
      $display("FAIL halted got st=%0d done=%0b cnt=%0d en=%0b want st=4 done=1 cnt=5 en=0",
               status, done, cycle_count, core_clk_en);
    end
    cyc(0, 1, C_STOP, 2'd0, 2'd0, 0);
    checks++;
    if (status !== 3'd0 || cycle_count !== 8'd0 || core_reset !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL halt_stop got st=%0d cnt=%0d rst=%0b done=%0b want st=0 cnt=0 rst=1 done=0",
               status, cycle_count, core_reset, done);
    end
  endtask

  task automatic test_timeout();
    cyc(0, 1, C_RUN, 2'd0, 2'd0, 0);
    idle_cycles(MAXC - 1);
    checks++;
    if (status !== 3'd1 || cycle_count !== 8'(MAXC - 1) || timeout !== 1'b0) begin
      failures++; $display("FAIL timeout_pre got st=%0d cnt=%0d want st=1 cnt=%0d", status, cycle_count, MAXC - 1);
    end
    idle_cycles(1);
    checks++;
    if (status !== 3'd5 || cycle_count !== 8'(MAXC) || timeout !== 1'b1 || core_clk_en !== 1'b0) begin
      failures++;
      $display("FAIL timeout got st=%0d cnt=%0d to=%0b en=%0b want st=5 cnt=%0d to=1 en=0",
               status, cycle_count, timeout, core_clk_en, MAXC);
    end
    idle_cycles(3);
    checks++;
    if (cycle_count !== 8'(MAXC) || status !== 3'd5) begin
      failures++; $display("FAIL timeout_hold got cnt=%0d st=%0d want cnt=%0d st=5", cycle_count, status, MAXC);
    end
    cyc(0, 1, C_RUN, 2'd0, 2'd0, 0);
    checks++;
    if (err !== 1'b1 || status !== 3'd5) begin
      failures++; $display("FAIL timeout_err got err=%0b st=%0d want err=1 st=5", err, status);
    end
    cyc(0, 1, C_STOP, 2'd0, 2'd0, 0);
    checks++;
    if (err !== 1'b0 || status !== 3'd0 || cycle_count !== 8'd0) begin
      failures++; $display("FAIL timeout_stop got err=%0b st=%0d cnt=%0d want 0/0/0", err, status, cycle_count);
    end
  endtask

  task automatic test_stop_step();
    cyc(0, 1, C_RUN, 2'd0, 2'd0, 0);
    idle_cycles(2);
    cyc(0, 1, C_STOP, 2'd0, 2'd0, 0);
    checks++;
    if (status !== 3'd3 || cycle_count !== 8'd3 || core_clk_en !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL paused got st=%0d cnt=%0d en=%0b err=%0b want st=3 cnt=3 en=0 err=0",
               status, cycle_count, core_clk_en, err);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, C_STEP, 2'd0, 2'd0, 0);
      checks++;
      if (status !== 3'd2 || cmd_ready !== 1'b0 || core_clk_en !== 1'b1 || cycle_count !== 8'(3 + k)) begin
        failures++;
        $display("FAIL step%0d_active got st=%0d rdy=%0b en=%0b cnt=%0d want st=2 rdy=0 en=1 cnt=%0d",
                 k, status, cmd_ready, core_clk_en, cycle_count, 3 + k);
      end
      // A STOP offered during STEP is not accepted.
      cyc(0, 1, C_STOP, 2'd0, 2'd0, 0);
      checks++;
      if (status !== 3'd3 || core_clk_en !== 1'b0 || cycle_count !== 8'(4 + k)) begin
        failures++;
        $display("FAIL step%0d_after got st=%0d en=%0b cnt=%0d want st=3 en=0 cnt=%0d",
                 k, status, core_clk_en, cycle_count, 4 + k);
      end
    end
  endtask

  task automatic test_illegal();
    // Continues from PAUSED, cycle_count=5.
    cyc(0, 1, C_LOAD, 2'd1, 2'd2, 0);
    checks++;
    if (err !== 1'b1 || prog_we !== 1'b0 || status !== 3'd3 || cycle_count !== 8'd5) begin
      failures++;
      $display("FAIL paused_load got err=%0b we=%0b st=%0d cnt=%0d want err=1 we=0 st=3 cnt=5",
               err, prog_we, status, cycle_count);
    end
    idle_cycles(1);
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_pulse_width got=%0b want=0", err);
    end
    cyc(0, 1, C_RUN, 2'd0, 2'd0, 0);
    cyc(0, 0, C_LOAD, 2'd0, 2'd0, 1);
    cyc(0, 1, C_RUN, 2'd0, 2'd0, 0);
    checks++;
    if (err !== 1'b1 || status !== 3'd4 || done !== 1'b1 || core_clk_en !== 1'b0) begin
      failures++;
      $display("FAIL halted_run got err=%0b st=%0d done=%0b en=%0b want err=1 st=4 done=1 en=0",
               err, status, done, core_clk_en);
    end
    idle_cycles(1);
    checks++;
    if (err !== 1'b0 || status !== 3'd4) begin
      failures++; $display("FAIL halted_err_clear got err=%0b st=%0d want 0/4", err, status);
    end
    cyc(0, 1, C_STOP, 2'd0, 2'd0, 0);
  endtask

  task automatic test_priority();
    cyc(0, 1, C_RUN, 2'd0, 2'd0, 0);
    cyc(0, 1, C_STOP, 2'd0, 2'd0, 1);
    checks++;
    if (status !== 3'd4 || err !== 1'b0) begin
      failures++; $display("FAIL halt_over_stop got st=%0d err=%0b want st=4 err=0", status, err);
    end
    cyc(0, 1, C_STOP, 2'd0, 2'd0, 0);
    cyc(0, 1, C_RUN, 2'd0, 2'd0, 0);
    idle_cycles(MAXC - 1);
    cyc(0, 1, C_STOP, 2'd0, 2'd0, 0);
    checks++;
    if (status !== 3'd5 || err !== 1'b0 || cycle_count !== 8'(MAXC)) begin
      failures++;
      $display("FAIL watchdog_over_stop got st=%0d err=%0b cnt=%0d want st=5 err=0 cnt=%0d",
               status, err, cycle_count, MAXC);
    end
    cyc(0, 1, C_STOP, 2'd0, 2'd0, 0);
  endtask

  task automatic test_reset_mid();
    logic [21:0] want;
    want = {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0};
    cyc(0, 1, C_LOAD, 2'd2, 2'd3, 0);
    cyc(0, 1, C_RUN, 2'd0, 2'd0, 0);
    idle_cycles(2);
    cyc(1, 1, C_STOP, 2'd0, 2'd0, 1);
    checks++;
    if (pack_obs() !== want) begin
      failures++; $display("FAIL reset_mid_run got=%h want=%h", pack_obs(), want);
    end
    cyc(0, 1, C_STEP, 2'd0, 2'd0, 0);
    cyc(1, 0, C_LOAD, 2'd0, 2'd0, 0);
    checks++;
    if (pack_obs() !== want) begin
      failures++; $display("FAIL reset_mid_step got=%h want=%h", pack_obs(), want);
    end
    cyc(1, 1, C_LOAD, 2'd3, 2'd1, 0);
    checks++;
    if (prog_we !== 1'b0 || prog_waddr !== 2'd0 || prog_wdata !== 2'd0) begin
      failures++; $display("FAIL reset_cancels_load got we=%0b a=%0d d=%0d want 0/0/0", prog_we, prog_waddr, prog_wdata);
    end
    cyc(0, 0, C_LOAD, 2'd0, 2'd0, 0);
  endtask

  task automatic test_random();
    logic [21:0] obs, exp;
    bit          rst, v, h;
    logic [1:0]  op, a, d;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 2) != 0);
      op  = 2'($urandom_range(0, 3));
      a   = 2'($urandom_range(0, 3));
      d   = 2'($urandom_range(0, 3));
      h   = ($urandom_range(0, 14) == 0);
      cyc(rst, v, op, a, d, h);
      obs = pack_obs();
      exp = model_vec();
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL random_cycle%0d got=%h want=%h", n, obs, exp);
      end
      checks++;
      if (prog_we === 1'b1 && core_clk_en === 1'b1) begin
        failures++; $display("FAIL we_vs_clken cycle%0d got we=1 en=1 want not both", n);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 2'd0; cmd_data = 2'd0; core_halt = 1'b0;
    test_reset();
    test_load_run();
    test_halt();
    test_timeout();
    test_stop_step();
    test_illegal();
    test_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paper_run_ctrl.md
PAPER_RUN_CTRL -- requirements
Module: paper_run_ctrl

Interface
REQ-001 Parameter: MAX_CYCLES, 64, watchdog limit on enabled core cycles; legal range 1..255.
REQ-002 Parameter: PROG_DEPTH, 4, instruction-memory entries; fixed by the 2-bit program counter.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_op  in  2  command: 0 LOAD, 1 RUN, 2 STEP, 3 STOP.
REQ-007 cmd_addr  in  2  LOAD target address.
REQ-008 cmd_data  in  2  LOAD instruction word.
REQ-009 cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
REQ-010 core_halt  in  1  halt decode from the processor core.
REQ-011 core_clk_en  out  1  clock enable to core, program counter and register counter.
REQ-012 core_reset  out  1  active-high reset to core and counters.
REQ-013 prog_we / prog_waddr / prog_wdata  out  1/2/2  instruction-memory write port.
REQ-014 cycle_count  out  8  enabled core cycles since last core reset.
REQ-015 status  out  3  current FSM state encoding.
REQ-016 done / timeout / err  out  1/1/1  halted level, watchdog level, illegal-command one-cycle pulse.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, STEP, PAUSED, HALTED, TIMEOUT.
REQ-018 core_reset SHALL be 1 exactly in IDLE; core_clk_en SHALL be 1 exactly in RUN and STEP.
REQ-019 cmd_ready SHALL be 1 in every state except STEP.
REQ-020 IDLE: LOAD SHALL drive prog_we=1, prog_waddr=cmd_addr, prog_wdata=cmd_data in the next cycle only, staying in IDLE; RUN -> RUN; STEP -> STEP; STOP accepted, no effect.
REQ-021 RUN: each cycle SHALL increment cycle_count; core_halt=1 -> HALTED; increment reaching MAX_CYCLES -> TIMEOUT; STOP -> PAUSED; LOAD/RUN/STEP accepted, err pulse.
REQ-022 STEP: exactly one enabled cycle, cycle_count+1, then PAUSED (or HALTED/TIMEOUT under the same rules as RUN).
REQ-023 PAUSED: RUN -> RUN; STEP -> STEP; STOP -> IDLE; LOAD accepted, err pulse.
REQ-024 HALTED: done=1; STOP -> IDLE; any other op accepted, err pulse.
REQ-025 TIMEOUT: timeout=1; STOP -> IDLE; any other op accepted, err pulse.
REQ-026 Same-cycle priority in RUN/STEP SHALL be core_halt > watchdog > STOP; a STOP overridden this way is consumed without err.
REQ-027 cycle_count SHALL clear on entry to IDLE and saturate at MAX_CYCLES.
REQ-028 err SHALL be a single-cycle pulse in the cycle after the illegal command is accepted.
REQ-029 prog_we SHALL never be 1 while core_clk_en is 1.
REQ-030 All outputs SHALL be registered or decoded from the registered state only; no input-to-output combinational path except none.

Reset
REQ-031 reset=1 at any clock edge SHALL force IDLE, including mid-RUN or mid-STEP and during a pending LOAD write, which is cancelled.
REQ-032 Reset values: state IDLE, core_reset=1, core_clk_en=0, cmd_ready=1, prog_we=0, prog_waddr=0, prog_wdata=0, cycle_count=0, done=0, timeout=0, err=0.

Structure
REQ-033 Opcode values, state encodings, PROG_DEPTH and counter width SHALL live in a shared paper-processor package/header.
REQ-034 The saturating cycle counter SHALL be a sub-module paper_cycle_counter (clear, enable, limit, count, hit).

Verification
REQ-035 Reset, LOAD addr0..3 = {1,2,0,3}, RUN -> four prog_we pulses with matching addr/data, then core_clk_en=1 and core_reset=0 the cycle after RUN accepted.
REQ-036 RUN, core_halt asserted at cycle 5 -> HALTED, done=1, cycle_count=5, core_clk_en=0 next cycle; STOP -> IDLE, cycle_count=0.
REQ-037 MAX_CYCLES=8, RUN with core_halt=0 -> TIMEOUT after 8 enabled cycles, cycle_count=8, timeout=1.
REQ-038 RUN, STOP at cycle 3 -> PAUSED; STEP twice -> two single enabled cycles, cycle_count=5, cmd_ready=0 during each STEP.
REQ-039 LOAD while PAUSED, and RUN while HALTED -> err one-cycle pulse, no prog_we, state unchanged.
REQ-040 reset asserted mid-RUN and on a cycle with core_halt=1 and STOP both valid -> IDLE with all REQ-032 values next cycle.
